// File: rtl/rect_keysched_ctrl.sv
// rect_keysched_ctrl: RECTANGLE-80 key schedule sequencer for the decryption side.
// Loads an 80-bit master key and runs the forward schedule ROUNDS times.
// It then walks the schedule backwards and streams round keys K[ROUNDS]..K[0]
// over a valid/ready interface.
// Optional macro RECT_KEYSCHED_ENC_MODE_EN adds a 'mode' input. When mode=1 is
// sampled at start, the block emits the keys in encryption order K[0]..K[ROUNDS].
module rect_keysched_ctrl #(
  parameter int ROUNDS = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [79:0] key_in,
  input  logic        abort,
`ifdef RECT_KEYSCHED_ENC_MODE_EN
  input  logic        mode,
`endif
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [63:0] rk_out,
  output logic [4:0]  rk_idx,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST = 5'(ROUNDS);

  // Forward S-box and inverse S-box, packed as nibble tables (entry x at bits [4x+3:4x]).
  localparam logic [63:0] SBOX_TBL = 64'h24F8_D30B_97E1_AC56;
  localparam logic [63:0] ISBOX_TBL = 64'hD5B2_837C_601E_AF49;

  typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;

  state_t      state, state_n;
  logic [79:0] key_reg, key_n;
  logic [4:0]  rc, rc_n;
  logic [4:0]  idx, idx_n;
  logic [4:0]  cnt, cnt_n;
  logic        done_q, done_n;
  logic        enc_q, enc_n;

  function automatic logic [4:0] rc_adv(input logic [4:0] r);
    return {r[3:0], r[4] ^ r[2]};
  endfunction

  function automatic logic [4:0] rc_ret(input logic [4:0] r);
    return {r[0] ^ r[3], r[4:1]};
  endfunction

  // Substitute the four 4-bit columns formed by bit j of rows r3..r0 (r3 is the MSB).
  function automatic logic [79:0] sbox_layer(input logic [79:0] k, input logic inv);
    logic [15:0] r0, r1, r2, r3;
    logic [3:0]  nib, s;
    r0 = k[15:0];
    r1 = k[31:16];
    r2 = k[47:32];
    r3 = k[63:48];
    for (int j = 0; j < 4; j++) begin
      nib = {r3[j], r2[j], r1[j], r0[j]};
      s = inv ? ISBOX_TBL[{nib, 2'b00} +: 4] : SBOX_TBL[{nib, 2'b00} +: 4];
      r0[j] = s[0];
      r1[j] = s[1];
      r2[j] = s[2];
      r3[j] = s[3];
    end
    return {k[79:64], r3, r2, r1, r0};
  endfunction

  function automatic logic [79:0] fwd_step(input logic [79:0] k, input logic [4:0] r);
    logic [79:0] s;
    logic [15:0] s0, s1, s2, s3, r4;
    s  = sbox_layer(k, 1'b0);
    s0 = s[15:0];
    s1 = s[31:16];
    s2 = s[47:32];
    s3 = s[63:48];
    r4 = s[79:64];
    return {s0, {s3[3:0], s3[15:4]} ^ r4, s3, s2,
            ({s0[7:0], s0[15:8]} ^ s1) ^ {11'b0, r}};
  endfunction

  // Undo one forward step; r must already be the round constant used by that step.
  function automatic logic [79:0] inv_step(input logic [79:0] k, input logic [4:0] r);
    logic [15:0] s0, s1, s2, s3, r4;
    s0 = k[79:64];
    s1 = (k[15:0] ^ {11'b0, r}) ^ {s0[7:0], s0[15:8]};
    s2 = k[31:16];
    s3 = k[47:32];
    r4 = k[63:48] ^ {s3[3:0], s3[15:4]};
    return sbox_layer({r4, s3, s2, s1, s0}, 1'b1);
  endfunction

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      key_reg <= '0;
      rc      <= 5'h01;
      idx     <= '0;
      cnt     <= '0;
      done_q  <= 1'b0;
      enc_q   <= 1'b0;
    end else begin
      state   <= state_n;
      key_reg <= key_n;
      rc      <= rc_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      done_q  <= done_n;
      enc_q   <= enc_n;
    end
  end

  // Next-state logic: load, forward expansion, then one key step per accepted transfer.
  always_comb begin
    state_n = state;
    key_n   = key_reg;
    rc_n    = rc;
    idx_n   = idx;
    cnt_n   = cnt;
    done_n  = 1'b0;
    enc_n   = enc_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          key_n   = key_in;
          rc_n    = 5'h01;
          cnt_n   = '0;
          idx_n   = '0;
          enc_n   = 1'b0;
          state_n = FWD;
`ifdef RECT_KEYSCHED_ENC_MODE_EN
          enc_n = mode;
          if (mode) state_n = EMIT;
`endif
        end
      end
      FWD: begin
        if (abort) begin
          state_n = IDLE;
        end else if (cnt == LAST) begin
          state_n = EMIT;
          idx_n   = LAST;
        end else begin
          key_n = fwd_step(key_reg, rc);
          rc_n  = rc_adv(rc);
          cnt_n = cnt + 5'd1;
        end
      end
      EMIT: begin
        if (abort) begin
          state_n = IDLE;
        end else if (rk_ready) begin
          if (enc_q) begin
            if (idx == LAST) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              key_n = fwd_step(key_reg, rc);
              rc_n  = rc_adv(rc);
              idx_n = idx + 5'd1;
            end
          end else begin
            if (idx == 5'd0) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              rc_n  = rc_ret(rc);
              key_n = inv_step(key_reg, rc_ret(rc));
              idx_n = idx - 5'd1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rk_valid = (state == EMIT);
  assign rk_out   = key_reg[63:0];
  assign rk_idx   = idx;
  assign busy     = (state != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_rect_keysched_ctrl.sv
// Self-checking bench for rect_keysched_ctrl.
// The reference model expands the key schedule forward into a table of all
// round keys. Emitted keys are then checked against that table, in either order.
module tb_rect_keysched_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [79:0] key_in;
  logic        abort;
  logic        mode;
  logic        rk_valid;
  logic        rk_ready;
  logic [63:0] rk_out;
  logic [4:0]  rk_idx;
  logic        busy;
  logic        done;

  int total;
  int bad;

  logic [63:0] kexp [26];
  logic [3:0]  sb [16] = '{4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
                           4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2};

  rect_keysched_ctrl #(.ROUNDS(25)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .key_in(key_in),
    .abort(abort),
`ifdef RECT_KEYSCHED_ENC_MODE_EN
    .mode(mode),
`endif
    .rk_valid(rk_valid),
    .rk_ready(rk_ready),
    .rk_out(rk_out),
    .rk_idx(rk_idx),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: expand the schedule forward and record every round key.
  task automatic build_model(input logic [79:0] key);
    logic [15:0] r [5];
    logic [15:0] t0, t1;
    logic [3:0]  nib, s;
    int          rcv;
    for (int k = 0; k < 5; k++) r[k] = key[16*k +: 16];
    rcv = 1;
    for (int rnd = 0; rnd < 25; rnd++) begin
      kexp[rnd] = {r[3], r[2], r[1], r[0]};
      for (int j = 0; j < 4; j++) begin
        nib = {r[3][j], r[2][j], r[1][j], r[0][j]};
        s = sb[nib];
        for (int k = 0; k < 4; k++) r[k][j] = s[k];
      end
      t0 = r[0];
      t1 = r[1];
      r[0] = ((t0 << 8) | (t0 >> 8)) ^ t1 ^ 16'(rcv);
      r[1] = r[2];
      r[2] = r[3];
      r[3] = ((r[3] << 12) | (r[3] >> 4)) ^ r[4];
      r[4] = t0;
      rcv = ((rcv << 1) & 31) | (((rcv >> 4) ^ (rcv >> 2)) & 1);
    end
    kexp[25] = {r[3], r[2], r[1], r[0]};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (rk_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", rk_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    total++; if (rk_out !== 64'h0) begin bad++; $display("[TB] FAIL reset_out got=%h want=0", rk_out); end
    total++; if (rk_idx !== 5'd0) begin bad++; $display("[TB] FAIL reset_idx got=%0d want=0", rk_idx); end
    rst_n = 1'b1;
  endtask

  // Full decryption-order run. rmode: 0 always ready, 1 toggling, 2 random.
  task automatic test_decrypt(input logic [79:0] key, input int rmode, input bit poke);
    int n, e, guard;
    bit rdy;
    build_model(key);
    @(negedge clk);
    key_in = key; mode = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (rk_valid !== 1'b1 && n < 100) begin
      start = poke && (n == 5);
      @(posedge clk); n++; @(negedge clk);
    end
    start = 1'b0;
    total++; if (n != 26) begin bad++; $display("[TB] FAIL dec_latency got=%0d want=26", n); end
    e = 25; guard = 0;
    while (e >= 0 && guard < 200) begin
      total++; if (rk_valid !== 1'b1) begin bad++; $display("[TB] FAIL dec_valid idx=%0d got=%b want=1", e, rk_valid); end
      total++; if (rk_idx !== 5'(e)) begin bad++; $display("[TB] FAIL dec_idx got=%0d want=%0d", rk_idx, e); end
      total++; if (rk_out !== kexp[e]) begin bad++; $display("[TB] FAIL dec_key idx=%0d got=%h want=%h", e, rk_out, kexp[e]); end
      total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL dec_early_done idx=%0d got=%b want=0", e, done); end
      if (rmode == 0) rdy = 1'b1;
      else if (rmode == 1) rdy = (guard % 2 == 0);
      else rdy = 1'($urandom_range(0, 1));
      rk_ready = rdy;
      start = poke && (guard == 3);
      if (e == 0 && rdy) begin
        total++; if (rk_out !== key[63:0]) begin bad++; $display("[TB] FAIL dec_last_key got=%h want=%h", rk_out, key[63:0]); end
      end
      @(posedge clk); @(negedge clk);
      guard++;
      if (rdy) e--;
    end
    rk_ready = 1'b0; start = 1'b0;
    total++; if (e >= 0) begin bad++; $display("[TB] FAIL dec_timeout remaining=%0d want=-1", e); end
    total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL dec_done got=%b want=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL dec_idle got=%b want=0", busy); end
    total++; if (rk_valid !== 1'b0) begin bad++; $display("[TB] FAIL dec_valid_end got=%b want=0", rk_valid); end
    @(posedge clk); @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL dec_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_abort_fwd();
    @(negedge clk);
    key_in = {$urandom, $urandom, $urandom}; mode = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (9) begin @(posedge clk); @(negedge clk); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL abort_fwd_busy got=%b want=1", busy); end
    abort = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_fwd_idle got=%b want=0", busy); end
    total++; if (rk_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_fwd_valid got=%b want=0", rk_valid); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL abort_fwd_done got=%b want=0", done); end
    repeat (30) @(posedge clk);
    @(negedge clk);
    total++; if (rk_valid !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL abort_fwd_quiet got=%b%b want=00", rk_valid, done); end
  endtask

  task automatic test_abort_emit();
    int n;
    @(negedge clk);
    key_in = {$urandom, $urandom, $urandom}; mode = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    rk_ready = 1'b1;
    n = 0;
    while (!(rk_valid === 1'b1 && rk_idx === 5'd12) && n < 100) begin
      @(posedge clk); n++; @(negedge clk);
    end
    total++; if (rk_idx !== 5'd12) begin bad++; $display("[TB] FAIL abort_emit_reach got=%0d want=12", rk_idx); end
    abort = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0; start = 1'b0; rk_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_emit_idle got=%b want=0", busy); end
    total++; if (rk_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_emit_valid got=%b want=0", rk_valid); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL abort_emit_done got=%b want=0", done); end
    @(posedge clk); @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL abort_emit_done2 got=%b want=0", done); end
  endtask

  task automatic test_reset_mid_emit();
    int n;
    @(negedge clk);
    key_in = {$urandom, $urandom, $urandom}; mode = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    n = 0;
    while (rk_valid !== 1'b1 && n < 100) begin @(posedge clk); n++; @(negedge clk); end
    rk_ready = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rk_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    total++; if (rk_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_valid got=%b want=0", rk_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_busy got=%b want=0", busy); end
    total++; if (rk_out !== 64'h0) begin bad++; $display("[TB] FAIL rst_mid_out got=%h want=0", rk_out); end
    total++; if (rk_idx !== 5'd0) begin bad++; $display("[TB] FAIL rst_mid_idx got=%0d want=0", rk_idx); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_done got=%b want=0", done); end
    rst_n = 1'b1;
  endtask

`ifdef RECT_KEYSCHED_ENC_MODE_EN
  task automatic test_encrypt(input logic [79:0] key);
    int e, guard;
    bit rdy;
    build_model(key);
    @(negedge clk);
    key_in = key; mode = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; mode = 1'b0;
    e = 0; guard = 0;
    while (e <= 25 && guard < 200) begin
      total++; if (rk_valid !== 1'b1) begin bad++; $display("[TB] FAIL enc_valid idx=%0d got=%b want=1", e, rk_valid); end
      total++; if (rk_idx !== 5'(e)) begin bad++; $display("[TB] FAIL enc_idx got=%0d want=%0d", rk_idx, e); end
      total++; if (rk_out !== kexp[e]) begin bad++; $display("[TB] FAIL enc_key idx=%0d got=%h want=%h", e, rk_out, kexp[e]); end
      rdy = 1'($urandom_range(0, 1));
      rk_ready = rdy;
      @(posedge clk); @(negedge clk);
      guard++;
      if (rdy) e++;
    end
    rk_ready = 1'b0;
    total++; if (e <= 25) begin bad++; $display("[TB] FAIL enc_timeout idx=%0d want=26", e); end
    total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL enc_done got=%b want=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL enc_idle got=%b want=0", busy); end
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    start = 1'b0; key_in = '0; abort = 1'b0; mode = 1'b0; rk_ready = 1'b0; rst_n = 1'b0;
    test_reset();
    test_decrypt(80'h0123_456789AB_CDEFFEDC, 0, 1'b0);
    test_decrypt(80'h0, 1, 1'b0);
    test_decrypt(80'h0123_456789AB_CDEFFEDC, 2, 1'b1);
    test_abort_fwd();
    test_decrypt({$urandom, $urandom, $urandom}, 0, 1'b0);
    test_abort_emit();
    test_decrypt({$urandom, $urandom, $urandom}, 2, 1'b0);
    test_reset_mid_emit();
    test_decrypt({$urandom, $urandom, $urandom}, 1, 1'b1);
`ifdef RECT_KEYSCHED_ENC_MODE_EN
    test_encrypt(80'h0123_456789AB_CDEFFEDC);
    test_decrypt({$urandom, $urandom, $urandom}, 2, 1'b0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rect_keysched_ctrl.md
Name: rect_keysched_ctrl

Overview:
- Sequencer for the RECTANGLE-80 key schedule on the decryption side.
- Loads an 80-bit master key and runs the forward schedule ROUNDS times to reach the final key state.
- Then walks the schedule backwards, one inverse step per accepted round key, using the inverse key S-box layer.
- Emits round keys K[ROUNDS] down to K[0] over a valid/ready stream to the decryption datapath.

Parameters:
ROUNDS, 25, number of cipher rounds; ROUNDS+1 round keys are emitted; index width is 5 bits (ROUNDS must be ≤31).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  load key_in and begin; accepted only in IDLE
key_in  input  80  master key; rows r0=[15:0], r1=[31:16], r2=[47:32], r3=[63:48], r4=[79:64]
abort  input  1  synchronous return to IDLE, no done pulse
rk_valid  output  1  rk_out/rk_idx valid
rk_ready  input  1  consumer accepts the current round key
rk_out  output  64  round key = key_reg[63:0]
rk_idx  output  5  index of rk_out (ROUNDS down to 0)
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse after K[0] is accepted

Behaviour:
- Reset (rst_n=0 at a clk edge) takes priority over everything and clears all registers mid-operation:
  - state=IDLE, key_reg=0, rc=5'h01, idx=0.
  - rk_valid=0, busy=0, done=0, rk_out=0, rk_idx=0.
- S-box column j (j=0..3) is nibble {r3[j],r2[j],r1[j],r0[j]}; r3 is the MSB.
- Forward step:
  - Apply forward S-box to columns 0..3.
  - r0'=(r0<<<8)^r1, r1'=r2, r2'=r3, r3'=(r3<<<12)^r4, r4'=r0.
  - r0'[4:0] ^= rc.
  - Advance rc: rc={rc[3:0], rc[4]^rc[2]}.
- Inverse step:
  - Retreat rc first: rc={rc[0]^rc[3], rc[4:1]}.
  - Then with the retreated rc: r0=r4', r1=(r0'^{11'b0,rc})^(r0<<<8), r2=r1', r3=r2', r4=r3'^(r3<<<12).
  - Then apply inverse S-box to columns 0..3.
- RC sequence from 5'h01: 01,02,04,09,12,05,0B,16,0C,19,...,1D (RC24); RC25=1A.
- State machine:
  - IDLE: start=1 → key_reg=key_in, rc=5'h01, cnt=0, go to FWD. start in any other state is ignored.
  - FWD: one forward step per cycle; cnt++. After ROUNDS steps go to EMIT with idx=ROUNDS; rc then holds RC[ROUNDS].
  - EMIT: rk_valid=1, rk_out=key_reg[63:0], rk_idx=idx.
    - On rk_valid&rk_ready with idx==0: go to IDLE and pulse done next cycle.
    - On rk_valid&rk_ready with idx>0: key_reg=inverse step, idx--, stay in EMIT.
- Timing:
  - rk_valid rises exactly ROUNDS+1 cycles after the start-accept edge.
  - Throughput is one key per cycle while rk_ready=1.
- Handshake rules:
  - rk_out/rk_idx are stable while rk_valid=1 and rk_ready=0.
  - rk_valid never drops without a transfer, except on abort or reset.
- Abort:
  - In FWD or EMIT, abort=1 → IDLE next cycle, rk_valid=0, no done pulse.
  - abort has priority over start and over the handshake in the same cycle.
- Invariant: the final K[0] equals key_in[63:0].

Optional Feature:
- Macro: RECT_KEYSCHED_ENC_MODE_EN.
- Defined:
  - Adds input mode (1 bit), sampled at start.
  - mode=1 selects encryption order: skip FWD, go straight to EMIT with idx=0 and rc=5'h01.
  - Each accept performs a forward step and idx++; after K[ROUNDS] is accepted → IDLE with done.
  - rk_idx counts 0..ROUNDS.
  - mode=0 behaves exactly as the base block.
- Undefined: no mode port; decryption order only.

Test Plan:
- key_in=80'h0123_456789AB_CDEFFEDC, start, rk_ready=1 → rk_valid rises 26 cycles after start; 26 transfers with rk_idx 25..0 on consecutive cycles; last rk_out=64'h456789AB_CDEFFEDC; done pulses once.
- key_in=0, rk_ready toggling 1/0 each cycle → rk_out/rk_idx held during stalls; 26 transfers; final rk_out=64'h0.
- start asserted again while busy, during both FWD and EMIT → ignored; sequence identical to the uninterrupted run.
- abort in FWD at cycle 10, and in EMIT at rk_idx=12 → IDLE next cycle, rk_valid=0, no done; a later start produces the full correct sequence.
- rst_n=0 mid-EMIT → all outputs 0 on the next edge, state IDLE; rc restarts at 5'h01 on the next start.
- With RECT_KEYSCHED_ENC_MODE_EN, mode=1, same key → first rk_out=64'h456789AB_CDEFFEDC, rk_idx 0..25; the emitted set equals the mode=0 set in reverse order.
